// File: rtl/gs_line_filter.sv
// Separable-stage 1-D Gaussian line filter: 3-tap [1 2 1]/4 or 5-tap [1 4 6 4 1]/16
// with border replication, end-of-line flush, rounding and sticky error flags.
module gs_line_filter #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LINE_W = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic          ram0_valid_in,
  input  logic [DW-1:0] ram0_data_in,
  input  logic          ram1_valid_in,
  input  logic [DW-1:0] ram1_data_in,
  output logic          op_valid_out,
  output logic [DW-1:0] op_data_out,
  output logic          op_last_out,
  output logic          busy,
  output logic          err_collision,
  output logic          err_overrun
);

  localparam int unsigned   CW     = $clog2(LINE_W + 2);
  localparam int unsigned   SW     = DW + 4;
  localparam logic [CW-1:0] LAST_N = CW'(LINE_W - 1);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic          tap5_q, tap5_d;
  logic [DW-1:0] win_q [5];
  logic [DW-1:0] win_d [5];

  logic          v1_q, v2_q, op_valid_q;
  logic          tap5_p1_q, tap5_p2_q;
  logic          last1_q, last2_q, op_last_q;
  logic [SW-1:0] sum_q, sum_d;
  logic [DW-1:0] op_data_q, round_d;
  logic          busy_q, busy_d;
  logic          err_col_q, err_col_d;
  logic          err_ovr_q, err_ovr_d;

  logic          one_valid, both_valid, any_valid;
  logic          accept, first_px, flush_step, tap5_eff;
  logic          produce, last_step;
  logic [CW-1:0] radius, n_inc;
  logic [DW-1:0] in_data;

  always_comb begin : decode
    one_valid  = ram0_valid_in ^ ram1_valid_in;
    both_valid = ram0_valid_in & ram1_valid_in;
    any_valid  = ram0_valid_in | ram1_valid_in;
    in_data    = ram0_valid_in ? ram0_data_in : ram1_data_in;
    accept     = one_valid && (state_q != S_FLUSH) && !start;
    first_px   = accept && (n_q == '0);
    // Kernel choice is taken live from mode on pixel 0 so that pixel already uses it
    tap5_eff   = first_px ? mode : tap5_q;
    radius     = tap5_eff ? CW'(2) : CW'(1);
    n_inc      = n_q + CW'(1);
    flush_step = (state_q == S_FLUSH) && !start;
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_reg
    if (!rst_n) begin
      state_q <= S_FILL;
      n_q     <= '0;
      tap5_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      tap5_q  <= tap5_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    n_d     = n_q;
    tap5_d  = tap5_eff;
    if (start) begin
      state_d = S_FILL;
      n_d     = '0;
      tap5_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (accept) begin
            n_d = n_inc;
            if (n_inc == radius) state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            n_d = n_inc;
            if (n_q == LAST_N) state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          n_d = n_inc;
          if (n_q == LAST_N + radius) begin
            state_d = S_FILL;
            n_d     = '0;
          end
        end
        default: begin
          state_d = S_FILL;
          n_d     = '0;
        end
      endcase
    end
  end

  always_comb begin : fsm_out
    produce   = (accept && (n_q >= radius)) || flush_step;
    last_step = flush_step && (n_q == LAST_N + radius);
    err_col_d = !start && (err_col_q || both_valid);
    err_ovr_d = !start && (err_ovr_q || ((state_q == S_FLUSH) && any_valid));
    busy_d    = !start && ((state_d != S_FILL) || (n_d != '0) || produce || v1_q || v2_q);
  end

  // Flush cycles keep w0 in place while shifting, replicating the right border
  always_comb begin : win_next
    win_d = win_q;
    if (start) begin
      win_d = '{default: '0};
    end else if (first_px) begin
      win_d = '{default: in_data};
    end else if (accept || flush_step) begin
      win_d[0] = accept ? in_data : win_q[0];
      for (int unsigned k = 1; k < 5; k++) win_d[k] = win_q[k-1];
    end
  end

  always_comb begin : sum_stage
    if (tap5_p1_q) begin
      sum_d = SW'(win_q[0]) + (SW'(win_q[1]) << 2) + (SW'(win_q[2]) << 2)
            + (SW'(win_q[2]) << 1) + (SW'(win_q[3]) << 2) + SW'(win_q[4]);
    end else begin
      sum_d = SW'(win_q[0]) + (SW'(win_q[1]) << 1) + SW'(win_q[2]);
    end
  end

  always_comb begin : round_stage
    if (tap5_p2_q) round_d = DW'((sum_q + SW'(8)) >> 4);
    else           round_d = DW'((sum_q + SW'(2)) >> 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      win_q      <= '{default: '0};
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      op_valid_q <= 1'b0;
      tap5_p1_q  <= 1'b0;
      tap5_p2_q  <= 1'b0;
      last1_q    <= 1'b0;
      last2_q    <= 1'b0;
      op_last_q  <= 1'b0;
      sum_q      <= '0;
      op_data_q  <= '0;
      busy_q     <= 1'b0;
      err_col_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      win_q      <= win_d;
      v1_q       <= produce;
      tap5_p1_q  <= tap5_eff;
      last1_q    <= last_step;
      v2_q       <= v1_q && !start;
      tap5_p2_q  <= tap5_p1_q;
      last2_q    <= last1_q && !start;
      sum_q      <= sum_d;
      op_valid_q <= v2_q && !start;
      op_last_q  <= v2_q && last2_q && !start;
      if (v2_q && !start) op_data_q <= round_d;
      busy_q     <= busy_d;
      err_col_q  <= err_col_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  assign op_valid_out  = op_valid_q;
  assign op_data_out   = op_data_q;
  assign op_last_out   = op_last_q;
  assign busy          = busy_q;
  assign err_collision = err_col_q;
  assign err_overrun   = err_ovr_q;

endmodule
